mux4_scan_ctrl: RTL and testbench



---
 rtl/mux4_scan_ctrl_pkg.sv | 29 ++
 rtl/mux4_scan_ctrl_next_ch4.sv | 29 ++
 rtl/mux4_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_mux4_scan_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared definitions for the 4:1 mux scan controller: FSM state encodings,
// channel-index-to-select mapping and the lowest-enabled-channel helper.
package mux4_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DWELL  = 2'd1,
    ST_MANUAL = 2'd2
  } state_e;

  // Channel index is {S0,S1}: S0 is the select MSB.
  localparam logic [1:0] CH_X0 = 2'b00;
  localparam logic [1:0] CH_X1 = 2'b01;
  localparam logic [1:0] CH_X2 = 2'b10;
  localparam logic [1:0] CH_X3 = 2'b11;

  localparam int NUM_CH = 4;

  function automatic logic [1:0] first_en(input logic [3:0] mask);
    logic [1:0] idx;
    idx = CH_X0;
    if (mask[0])      idx = CH_X0;
    else if (mask[1]) idx = CH_X1;
    else if (mask[2]) idx = CH_X2;
    else if (mask[3]) idx = CH_X3;
    return idx;
  endfunction

endpackage

// File: rtl/mux4_scan_ctrl_next_ch4.sv
// Combinational round-robin picker: next enabled channel strictly above the
// current one, wrapping to the lowest enabled channel when none is above.
module next_ch4
  import mux4_scan_ctrl_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic [3:0] mask_i,
  output logic [1:0] next_o,
  output logic       wrap_o,
  output logic       none_o
);

  logic found;

  always_comb begin
    found  = 1'b0;
    next_o = first_en(mask_i);
    none_o = (mask_i == 4'b0000);
    // Descending scan so the last hit is the lowest enabled index above cur_i.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(cur_i))) begin
        next_o = 2'(i);
        found  = 1'b1;
      end
    end
    wrap_o = !found && !none_o;
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Select generator for a 4:1 mux: scans enabled channels with a programmable
// dwell (or follows SEL_IN in manual mode) and captures Y per channel.
module mux4_scan_ctrl
  import mux4_scan_ctrl_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic               MODE,
  input  logic [1:0]         SEL_IN,
  input  logic [3:0]         MASK,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic               Y,
  output logic               S0,
  output logic               S1,
  output logic [3:0]         SAMPLE,
  output logic               SWEEP_DONE,
  output logic               BUSY
);

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [3:0]         sample_q, sample_d;
  logic               sweep_q, sweep_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [1:0]         nxt_ch;
  logic               nxt_wrap;
  logic               nxt_none;

  assign dwell_eff = (DWELL == '0) ? DWELL_W'(1) : DWELL;

  next_ch4 u_next_ch4 (
    .cur_i  (sel_q),
    .mask_i (MASK),
    .next_o (nxt_ch),
    .wrap_o (nxt_wrap),
    .none_o (nxt_none)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    sweep_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (EN) begin
          if (MODE) begin
            state_d = ST_MANUAL;
          end else if (MASK != 4'b0000) begin
            state_d = ST_DWELL;
            sel_d   = first_en(MASK);
            cnt_d   = dwell_eff;
          end
        end
      end

      ST_DWELL: begin
        if (!EN) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (MODE) begin
          state_d = ST_MANUAL;
          cnt_d   = '0;
        end else if (cnt_q > DWELL_W'(1)) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          // Last cycle of the dwell: capture, then advance or stop.
          sample_d[sel_q] = Y;
          if (nxt_none) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            sel_d   = nxt_ch;
            cnt_d   = dwell_eff;
            sweep_d = nxt_wrap;
          end
        end
      end

      ST_MANUAL: begin
        if (!EN) begin
          state_d = ST_IDLE;
        end else if (!MODE) begin
          if (MASK != 4'b0000) begin
            state_d = ST_DWELL;
            sel_d   = first_en(MASK);
            cnt_d   = dwell_eff;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          sel_d           = SEL_IN;
          sample_d[sel_q] = Y;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      sel_q    <= CH_X0;
      cnt_q    <= '0;
      sample_q <= 4'b0000;
      sweep_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      sweep_q  <= sweep_d;
    end
  end

  assign S0         = sel_q[1];
  assign S1         = sel_q[0];
  assign SAMPLE     = sample_q;
  assign SWEEP_DONE = sweep_q;
  assign BUSY       = (state_q == ST_DWELL);

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl with a behavioural 4:1 mux closing the Y loop.
module tb_mux4_scan_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       MODE;
  logic [1:0] SEL_IN;
  logic [3:0] MASK;
  logic [3:0] DWELL;
  logic       Y;
  logic       S0;
  logic       S1;
  logic [3:0] SAMPLE;
  logic       SWEEP_DONE;
  logic       BUSY;

  logic [3:0] x_vec;
  int         pass_cnt;
  int         total_cnt;

  mux4_scan_ctrl #(.DWELL_W(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .MODE       (MODE),
    .SEL_IN     (SEL_IN),
    .MASK       (MASK),
    .DWELL      (DWELL),
    .Y          (Y),
    .S0         (S0),
    .S1         (S1),
    .SAMPLE     (SAMPLE),
    .SWEEP_DONE (SWEEP_DONE),
    .BUSY       (BUSY)
  );

  assign Y = x_vec[{S0, S1}];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    $display("check %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] sel, input logic [3:0] smp,
                         input logic swp, input logic bsy);
    chk({tag, ".sel"},   8'({S0, S1}), 8'(sel));
    chk({tag, ".samp"},  8'(SAMPLE), 8'(smp));
    chk({tag, ".sweep"}, 8'(SWEEP_DONE), 8'(swp));
    chk({tag, ".busy"},  8'(BUSY), 8'(bsy));
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    RST_N  = 1'b0;
    EN     = 1'b0;
    MODE   = 1'b0;
    SEL_IN = 2'b00;
    MASK   = 4'b0000;
    DWELL  = 4'd0;
    x_vec  = 4'b0000;

    tick(2);
    chk_all("reset", 2'b00, 4'b0000, 1'b0, 1'b0);
    RST_N = 1'b1;

    // Full sweep, MASK=1111, DWELL=3, X3..X0=1010
    MASK  = 4'b1111;
    DWELL = 4'd3;
    x_vec = 4'b1010;
    EN    = 1'b1;
    tick(1);  chk_all("sweep_e1",  2'b00, 4'b0000, 1'b0, 1'b1);
    tick(3);  chk_all("sweep_e4",  2'b01, 4'b0000, 1'b0, 1'b1);
    tick(3);  chk_all("sweep_e7",  2'b10, 4'b0010, 1'b0, 1'b1);
    tick(3);  chk_all("sweep_e10", 2'b11, 4'b0010, 1'b0, 1'b1);
    tick(2);  chk_all("sweep_e12", 2'b11, 4'b0010, 1'b0, 1'b1);
    tick(1);  chk_all("sweep_e13", 2'b00, 4'b1010, 1'b1, 1'b1);
    tick(1);  chk_all("sweep_e14", 2'b00, 4'b1010, 1'b0, 1'b1);

    // Asynchronous reset mid-dwell, asserted between edges
    #2 RST_N = 1'b0;
    #1 chk_all("async_rst", 2'b00, 4'b0000, 1'b0, 1'b0);
    EN = 1'b0;
    #1 RST_N = 1'b1;

    // Sparse mask 1001, DWELL=2
    MASK  = 4'b1001;
    DWELL = 4'd2;
    x_vec = 4'b1001;
    EN    = 1'b1;
    tick(1);  chk_all("sparse_a1", 2'b00, 4'b0000, 1'b0, 1'b1);
    tick(2);  chk_all("sparse_a3", 2'b11, 4'b0001, 1'b0, 1'b1);
    tick(2);  chk_all("sparse_a5", 2'b00, 4'b1001, 1'b1, 1'b1);
    tick(1);  chk_all("sparse_a6", 2'b00, 4'b1001, 1'b0, 1'b1);
    tick(3);  chk_all("sparse_a9", 2'b00, 4'b1001, 1'b1, 1'b1);
    EN = 1'b0;
    tick(1);  chk_all("sparse_off", 2'b00, 4'b1001, 1'b0, 1'b0);

    // DWELL=0, single channel X2
    MASK  = 4'b0100;
    DWELL = 4'd0;
    x_vec = 4'b0000;
    EN    = 1'b1;
    tick(1);  chk_all("single_b1", 2'b10, 4'b1001, 1'b0, 1'b1);
    x_vec = 4'b0100;
    tick(1);  chk_all("single_b2", 2'b10, 4'b1101, 1'b1, 1'b1);
    x_vec = 4'b0000;
    tick(1);  chk_all("single_b3", 2'b10, 4'b1001, 1'b1, 1'b1);
    EN = 1'b0;
    tick(1);  chk_all("single_off", 2'b10, 4'b1001, 1'b0, 1'b0);

    // Mask change 1111 -> 0010 during channel 0 dwell, then MASK=0 at an advance
    MASK  = 4'b1111;
    DWELL = 4'd2;
    x_vec = 4'b0110;
    EN    = 1'b1;
    tick(1);  chk_all("mchg_c1", 2'b00, 4'b1001, 1'b0, 1'b1);
    MASK = 4'b0010;
    tick(2);  chk_all("mchg_c3", 2'b01, 4'b1000, 1'b0, 1'b1);
    tick(2);  chk_all("mchg_c5", 2'b01, 4'b1010, 1'b1, 1'b1);
    MASK  = 4'b0000;
    x_vec = 4'b0100;
    tick(1);  chk_all("mchg_c6", 2'b01, 4'b1010, 1'b0, 1'b1);
    tick(1);  chk_all("mask0_c7", 2'b01, 4'b1000, 1'b0, 1'b0);

    // Manual mode
    MODE   = 1'b1;
    SEL_IN = 2'b11;
    x_vec  = 4'b0101;
    tick(1);  chk_all("man_d1", 2'b01, 4'b1000, 1'b0, 1'b0);
    tick(1);  chk_all("man_d2", 2'b11, 4'b1000, 1'b0, 1'b0);
    SEL_IN = 2'b01;
    tick(1);  chk_all("man_d3", 2'b01, 4'b0000, 1'b0, 1'b0);
    x_vec = 4'b0010;
    tick(1);  chk_all("man_d4", 2'b01, 4'b0010, 1'b0, 1'b0);
    EN     = 1'b0;
    SEL_IN = 2'b10;
    tick(1);  chk_all("man_off", 2'b01, 4'b0010, 1'b0, 1'b0);
    tick(1);  chk_all("idle_hold", 2'b01, 4'b0010, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
